// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer arbiter: display reads always own the RAM port, camera
// writes queue in a small in-order FIFO and drain on cycles with no read request.
module frame_buffer_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          rd_req_i,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          rd_valid_o,
  input  logic                          wr_valid_i,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  output logic                          wr_ready_o,
  input  logic                          overflow_clr_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;
  logic                  full, push, pop;

  always_comb begin
    full        = (level_q == LVL_FULL);
    push        = wr_valid_i && !full;
    pop         = !rd_req_i && (level_q != '0);
    state_d     = ST_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_req_i) begin
      state_d    = ST_READ;
      mem_addr_d = rd_addr_i;
    end else if (pop) begin
      state_d     = ST_WRITE;
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (!push && pop) level_d = level_q - LVL_ONE;

    // RAM returns data the cycle after the READ op; register it one more time.
    rd_pend_d  = (state_q == ST_READ);
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? mem_rdata_i : rd_data_q;

    overflow_d = overflow_q;
    if (wr_valid_i && full) overflow_d = 1'b1;
    else if (overflow_clr_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry storage needs no reset: the level/pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr_i;
      fifo_data_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign mem_en_o     = (state_q != ST_IDLE);
  assign mem_we_o     = (state_q == ST_WRITE);
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign wr_ready_o   = !full;
  assign overflow_o   = overflow_q;
  assign fifo_level_o = level_q;

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
- Shares one single-port frame-buffer RAM (320x240, 12-bit RGB444) between two requesters.
- The display read side is hard real-time and always wins the port.
- Camera pixel writes are buffered in an internal FIFO and drained into the RAM on cycles with no read request.
- Sits between the camera capture path, the VGA scan-out path (pixel-address consumer) and the block RAM.

Parameters:
- ADDR_WIDTH, 17, frame-buffer address width; $clog2(76800).
- DATA_WIDTH, 12, pixel width.
- FIFO_DEPTH, 8, write FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-high reset.
- rd_req_i  input  1  display read request, one pixel per asserted cycle.
- rd_addr_i  input  ADDR_WIDTH  display read address.
- rd_data_o  output  DATA_WIDTH  read pixel.
- rd_valid_o  output  1  rd_data_o valid strobe.
- wr_valid_i  input  1  camera write offered.
- wr_addr_i  input  ADDR_WIDTH  camera write address.
- wr_data_i  input  DATA_WIDTH  camera write pixel.
- wr_ready_o  output  1  FIFO not full; a write is accepted when wr_valid_i && wr_ready_o.
- overflow_clr_i  input  1  clears overflow_o.
- overflow_o  output  1  sticky flag: a write was offered while full.
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- mem_en_o  output  1  RAM enable.
- mem_we_o  output  1  RAM write enable.
- mem_addr_o  output  ADDR_WIDTH  RAM address.
- mem_wdata_o  output  DATA_WIDTH  RAM write data.
- mem_rdata_i  input  DATA_WIDTH  RAM read data; 1-cycle latency after mem_en_o && !mem_we_o.

Behaviour:
- Reset (async assert, sync release to clk_i): FIFO empty, state IDLE, all outputs 0 except wr_ready_o=1.
- State register (memory op issued this cycle): IDLE, READ, WRITE; next state decided from inputs in cycle N, mem_* registered and driven in N+1.
- Priority in cycle N:
  - rd_req_i=1 -> READ.
  - else FIFO non-empty -> WRITE, head popped in cycle N.
  - else IDLE.
- Reads are never delayed or dropped; writes can starve indefinitely while rd_req_i is held.
- READ in N+1: mem_en_o=1, mem_we_o=0, mem_addr_o=rd_addr_i sampled at N, mem_wdata_o holds last value.
- WRITE in N+1: mem_en_o=1, mem_we_o=1, mem_addr_o/mem_wdata_o = popped entry.
- IDLE: mem_en_o=0, mem_we_o=0; address/data hold their last values.
- Read latency fixed at 3: request in N -> rd_valid_o=1 and rd_data_o=RAM[addr] registered in N+3.
  - Back-to-back requests give back-to-back valids, in order.
  - rd_data_o holds its value when rd_valid_o=0.
- FIFO: in-order, push on accept, pop on WRITE grant.
  - Push and pop in the same cycle: level unchanged.
  - wr_ready_o=0 iff level==FIFO_DEPTH, derived from the registered level; a pop in the same cycle does not raise it early.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - wr_valid_i=1 && wr_ready_o=0 -> write dropped; overflow_o=1 next cycle, held until overflow_clr_i.
  - overflow_clr_i and a new overflow in the same cycle -> overflow_o stays 1 (set wins).
- Read-after-write to the same address: no forwarding. A read sees RAM contents, so FIFO-pending data is not visible.
- Reset mid-operation: in-flight read is discarded (no rd_valid_o); FIFO contents are lost; mem_en_o/mem_we_o drop to 0 immediately.

Test Plan:
- Reset, idle 10 cycles -> mem_en_o=0, rd_valid_o=0, wr_ready_o=1, fifo_level_o=0, overflow_o=0.
- Writes of 0xABC to addr 5, then 0x123 to addr 6, rd_req_i=0 -> mem_we_o pulses with addr 5 then 6 in order; read of addr 5 later returns 0xABC exactly 3 cycles after the request.
- rd_req_i held 20 cycles, addrs 0..19, while 3 writes are pushed -> 20 consecutive rd_valid_o with matching data, no mem_we_o during the burst, fifo_level_o=3, then the 3 writes drain in the next 3 cycles.
- rd_req_i held, 9 writes offered -> 8 accepted, wr_ready_o=0 after the 8th, 9th dropped, overflow_o=1; overflow_clr_i pulse -> overflow_o=0.
- Push of 4 entries with FIFO draining concurrently -> level tracks exactly; wrap-around across 3 full fills keeps data order intact, checked by readback.
- reset_i asserted mid-read-burst with FIFO at level 5 -> outputs zero asynchronously; after release, no stale rd_valid_o and no pending writes issued.
